pixel_mixer: RTL and testbench



---
 rtl/game_pkg.sv | 21 ++
 rtl/mixer_mode_ctrl.sv | 78 +++++++
 rtl/pixel_mixer.sv | 145 ++++++++++++++
 tb/tb_pixel_mixer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: mode encodings, colour type, default palettes and
// the active display size used by both the mixer and the VGA controller.
package game_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    MODE_PLAY = 2'd0,
    MODE_WIN  = 2'd1,
    MODE_LOSE = 2'd2
  } mode_e;

  // 1-bit-per-channel colour, {r, g, b}
  typedef logic [2:0] rgb3;

  localparam rgb3 PAL_LAYER_DEF   = 3'b110;
  localparam rgb3 PAL_BORDER0_DEF = 3'b111;
  localparam rgb3 PAL_BORDER1_DEF = 3'b011;

endpackage

// File: rtl/mixer_mode_ctrl.sv
// Frame-synchronous game mode, level latch and win/lose flash timer.
// Everything here only moves on frame_start, so a frame never tears.
module mixer_mode_ctrl
  import game_pkg::*;
#(
  parameter int FLASH_FRAMES = 30
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  frame_start,
  input  logic  level_sel,
  input  logic  win,
  input  logic  game_over,
  output mode_e mode,
  output logic  level,
  output logic  flash_on
);

  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLASH_FRAMES - 1);

  mode_e            mode_q, mode_nxt;
  logic             level_q, level_nxt;
  logic             flash_q, flash_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  // State register for mode, level, flash phase and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_PLAY;
      level_q <= 1'b0;
      flash_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      mode_q  <= mode_nxt;
      level_q <= level_nxt;
      flash_q <= flash_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Next state: transitions out of PLAY (loss wins ties), flash timing otherwise
  always_comb begin
    mode_nxt  = mode_q;
    level_nxt = level_q;
    flash_nxt = flash_q;
    cnt_nxt   = cnt_q;
    if (frame_start) begin
      case (mode_q)
        MODE_PLAY: begin
          level_nxt = level_sel;
          if (game_over) begin
            mode_nxt  = MODE_LOSE;
            cnt_nxt   = '0;
            flash_nxt = 1'b1;
          end else if (win) begin
            mode_nxt  = MODE_WIN;
            cnt_nxt   = '0;
            flash_nxt = 1'b1;
          end
        end
        default: begin
          if (cnt_q == CNT_MAX) begin
            cnt_nxt   = '0;
            flash_nxt = ~flash_q;
          end else begin
            cnt_nxt = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign mode     = mode_q;
  assign level    = level_q;
  assign flash_on = flash_q;

endmodule

// File: rtl/pixel_mixer.sv
// Two-stage pixel compositor: stage 1 registers hits and the border flag,
// stage 2 resolves the colour for the current mode and drives the VGA pins.
module pixel_mixer
  import game_pkg::*;
#(
  parameter int                    N_LAYERS     = 8,
  parameter int                    COLOR_W      = 8,
  parameter int                    H_ACTIVE     = VGA_H_ACTIVE,
  parameter int                    V_ACTIVE     = VGA_V_ACTIVE,
  parameter int                    BORDER_W     = 15,
  parameter int                    FLASH_FRAMES = 30,
  parameter int                    BLEND        = 0,
  parameter logic [3*N_LAYERS-1:0] LAYER_PAL    = {N_LAYERS{PAL_LAYER_DEF}},
  parameter logic [N_LAYERS-1:0]   TEXT_MASK    = '0,
  parameter rgb3                   BORDER_PAL0  = PAL_BORDER0_DEF,
  parameter rgb3                   BORDER_PAL1  = PAL_BORDER1_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          x_pos,
  input  logic [9:0]          y_pos,
  input  logic                pix_valid,
  input  logic                frame_start,
  input  logic [N_LAYERS-1:0] layer_hit,
  input  logic                text_hit,
  input  logic                level_sel,
  input  logic                win,
  input  logic                game_over,
  output logic [COLOR_W-1:0]  VGA_R,
  output logic [COLOR_W-1:0]  VGA_G,
  output logic [COLOR_W-1:0]  VGA_B,
  output logic                pix_valid_out,
  output logic                border_hit,
  output logic [1:0]          mode
);

  localparam logic [9:0] B_LO  = 10'(BORDER_W);
  localparam logic [9:0] X_HI  = 10'(H_ACTIVE - BORDER_W);
  localparam logic [9:0] Y_HI  = 10'(V_ACTIVE - BORDER_W);
  localparam logic [9:0] X_END = 10'(H_ACTIVE);
  localparam logic [9:0] Y_END = 10'(V_ACTIVE);

  mode_e mode_st;
  logic  level, flash_on;

  mixer_mode_ctrl #(.FLASH_FRAMES(FLASH_FRAMES)) u_mode (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .level_sel  (level_sel),
    .win        (win),
    .game_over  (game_over),
    .mode       (mode_st),
    .level      (level),
    .flash_on   (flash_on)
  );

  assign mode = mode_st;

  // ---- stage 1 ----
  logic                border_d;
  logic [N_LAYERS-1:0] hit_q;
  logic                text_q, pv_q;

  assign border_d = (x_pos < X_END) && (y_pos < Y_END) &&
                    ((x_pos < B_LO) || (x_pos >= X_HI) ||
                     (y_pos < B_LO) || (y_pos >= Y_HI));

  // Register raw hits and the geometric border flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= '0;
      text_q     <= 1'b0;
      pv_q       <= 1'b0;
      border_hit <= 1'b0;
    end else begin
      hit_q      <= layer_hit;
      text_q     <= text_hit;
      pv_q       <= pix_valid;
      border_hit <= border_d;
    end
  end

  // ---- stage 2: per-layer terms ----
  // seen[i] = some higher-priority layer already hit; pri_term is one-hot,
  // so OR-reducing it yields the winning layer's colour.
  logic [N_LAYERS-1:0]      eff;
  logic [N_LAYERS:0]        seen;
  logic [N_LAYERS-1:0][2:0] or_term, pri_term;

  assign seen[0] = 1'b0;

  for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
    assign eff[i]      = hit_q[i] & ~(TEXT_MASK[i] & text_q);
    assign seen[i+1]   = seen[i] | eff[i];
    assign or_term[i]  = eff[i] ? LAYER_PAL[3*i +: 3] : 3'b000;
    assign pri_term[i] = (eff[i] & ~seen[i]) ? LAYER_PAL[3*i +: 3] : 3'b000;
  end

  rgb3 layer_or, layer_pri, border_col, col;

  // Fold per-layer terms into blend and priority colours
  always_comb begin
    layer_or  = '0;
    layer_pri = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      layer_or  = layer_or | or_term[i];
      layer_pri = layer_pri | pri_term[i];
    end
  end

  // Pick the pixel colour for the current mode; text punches the border to black
  always_comb begin
    border_col = '0;
    if (border_hit && !text_q) border_col = level ? BORDER_PAL1 : BORDER_PAL0;
    col = '0;
    if (pv_q) begin
      case (mode_st)
        MODE_WIN:  col = {1'b0, text_q & flash_on, 1'b0};
        MODE_LOSE: col = {text_q & flash_on, 2'b00};
        default: begin
          if (BLEND != 0)      col = border_col | layer_or;
          else if (border_hit) col = border_col;
          else                 col = layer_pri;
        end
      endcase
    end
  end

  // Output register: expand 1-bit channels to full VGA width
  always_ff @(posedge clk) begin
    if (rst) begin
      VGA_R         <= '0;
      VGA_G         <= '0;
      VGA_B         <= '0;
      pix_valid_out <= 1'b0;
    end else begin
      VGA_R         <= {COLOR_W{col[2]}};
      VGA_G         <= {COLOR_W{col[1]}};
      VGA_B         <= {COLOR_W{col[0]}};
      pix_valid_out <= pv_q;
    end
  end

endmodule

// File: tb/tb_pixel_mixer.sv
// Bench for pixel_mixer: a priority instance and a blend instance share stimulus;
// outputs are compared against a frame-level behavioural model.
module tb_pixel_mixer;

  localparam int NL = 8;
  localparam int FF = 2;
  // layer 0 = 100, 1 = 101, 2 = 010, 3 = 001, 4 = 110, 5 = 011, 6 = 111, 7 = 100
  localparam logic [3*NL-1:0] PAL =
    {3'b100, 3'b111, 3'b011, 3'b110, 3'b001, 3'b010, 3'b101, 3'b100};
  localparam logic [NL-1:0] TMASK = 8'b0010_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    x_pos = '0, y_pos = '0;
  logic          pix_valid = 1'b0, frame_start = 1'b0, text_hit = 1'b0;
  logic          level_sel = 1'b0, win = 1'b0, game_over = 1'b0;
  logic [NL-1:0] layer_hit = '0;
  logic [7:0]    r0, g0, b0, r1, g1, b1;
  logic          pvo0, pvo1, bh0, bh1;
  logic [1:0]    md0, md1;

  always #5 clk = ~clk;

  pixel_mixer #(.N_LAYERS(NL), .FLASH_FRAMES(FF), .BLEND(0), .LAYER_PAL(PAL),
                .TEXT_MASK(TMASK)) dut0 (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .pix_valid(pix_valid),
    .frame_start(frame_start), .layer_hit(layer_hit), .text_hit(text_hit),
    .level_sel(level_sel), .win(win), .game_over(game_over),
    .VGA_R(r0), .VGA_G(g0), .VGA_B(b0), .pix_valid_out(pvo0),
    .border_hit(bh0), .mode(md0));

  pixel_mixer #(.N_LAYERS(NL), .FLASH_FRAMES(FF), .BLEND(1), .LAYER_PAL(PAL),
                .TEXT_MASK(TMASK)) dut1 (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .pix_valid(pix_valid),
    .frame_start(frame_start), .layer_hit(layer_hit), .text_hit(text_hit),
    .level_sel(level_sel), .win(win), .game_over(game_over),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .pix_valid_out(pvo1),
    .border_hit(bh1), .mode(md1));

  int vectors = 0;
  int miscompares = 0;

  // model state
  int          m_mode;   // 0 play, 1 win, 2 lose
  bit          m_level, m_flash;
  int          m_cnt;
  logic [23:0] pend0, pend1, exp0, exp1;
  bit          pend_pv, exp_pv, exp_bh;

  function automatic bit is_border(int x, int y);
    if (x >= 640 || y >= 480) return 1'b0;
    return (x < 15) || (x >= 625) || (y < 15) || (y >= 465);
  endfunction

  function automatic logic [23:0] expand(logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  function automatic logic [23:0] model_rgb(bit blend, int x, int y, bit pv,
                                            logic [NL-1:0] hit, bit txt);
    logic [3*NL-1:0] pal_v = PAL;
    logic [NL-1:0]   mask_v = TMASK;
    logic [2:0]      c = 3'b000, bc = 3'b000;
    bit              found = 1'b0;
    if (!pv) return 24'h0;
    if (m_mode == 1) return expand({1'b0, txt & m_flash, 1'b0});
    if (m_mode == 2) return expand({txt & m_flash, 2'b00});
    if (is_border(x, y) && !txt) bc = m_level ? 3'b011 : 3'b111;
    if (blend) begin
      c = bc;
      for (int i = 0; i < NL; i++)
        if (hit[i] && !(mask_v[i] && txt)) c = c | pal_v[3*i +: 3];
    end else if (is_border(x, y)) begin
      c = bc;
    end else begin
      for (int i = 0; i < NL; i++)
        if (!found && hit[i] && !(mask_v[i] && txt)) begin
          c = pal_v[3*i +: 3];
          found = 1'b1;
        end
    end
    return expand(c);
  endfunction

  // Apply one pixel, advance the model, clock once and settle. After return,
  // exp0/exp1/exp_pv describe the pixel applied on the previous call and
  // exp_bh the one just applied.
  task automatic cyc(input bit r, input int x, input int y, input bit pv, input bit fs,
                     input logic [NL-1:0] hit, input bit t, input bit ls,
                     input bit w, input bit go);
    rst = r; x_pos = x[9:0]; y_pos = y[9:0]; pix_valid = pv; frame_start = fs;
    layer_hit = hit; text_hit = t; level_sel = ls; win = w; game_over = go;
    if (r) begin
      m_mode = 0; m_level = 1'b0; m_flash = 1'b1; m_cnt = 0;
      pend0 = '0; pend1 = '0; pend_pv = 1'b0;
      exp0 = '0; exp1 = '0; exp_pv = 1'b0; exp_bh = 1'b0;
    end else begin
      if (fs) begin
        if (m_mode == 0) begin
          m_level = ls;
          if (go)     begin m_mode = 2; m_cnt = 0; m_flash = 1'b1; end
          else if (w) begin m_mode = 1; m_cnt = 0; m_flash = 1'b1; end
        end else if (m_cnt == FF - 1) begin
          m_cnt = 0; m_flash = !m_flash;
        end else begin
          m_cnt++;
        end
      end
      exp0 = pend0; exp1 = pend1; exp_pv = pend_pv;
      pend0 = model_rgb(1'b0, x, y, pv, hit, t);
      pend1 = model_rgb(1'b1, x, y, pv, hit, t);
      pend_pv = pv;
      exp_bh = is_border(x, y);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, $urandom_range(0, 1),
          NL'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 1'b1);
      vectors++;
      if ({r0, g0, b0, r1, g1, b1} !== 48'h0) begin
        miscompares++; $display("FAIL reset_rgb got %h/%h exp 0", {r0, g0, b0}, {r1, g1, b1});
      end
      vectors++;
      if ({md0, md1, bh0, bh1, pvo0, pvo1} !== 8'h0) begin
        miscompares++; $display("FAIL reset_ctl mode %0d border %b pvo %b exp 0", md0, bh0, pvo0);
      end
    end
    cyc(1'b0, 0, 0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 100, 100, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0} !== 24'hFFFFFF || exp0 !== 24'hFFFFFF) begin
      miscompares++; $display("FAIL reset_corner got %h exp ffffff", {r0, g0, b0});
    end
  endtask

  task automatic test_priority_blend();
    cyc(1'b0, 100, 100, 1'b1, 1'b0, 8'b0000_0110, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 100, 100, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0} !== 24'hFF00FF) begin
      miscompares++; $display("FAIL priority got %h exp ff00ff", {r0, g0, b0});
    end
    vectors++;
    if ({r1, g1, b1} !== 24'hFFFFFF) begin
      miscompares++; $display("FAIL blend got %h exp ffffff", {r1, g1, b1});
    end
  endtask

  task automatic test_text_mask();
    cyc(1'b0, 100, 100, 1'b1, 1'b0, 8'b0000_1000, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 100, 100, 1'b1, 1'b0, 8'b0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0, r1, g1, b1} !== 48'h0) begin
      miscompares++; $display("FAIL text_mask_on got %h/%h exp 0", {r0, g0, b0}, {r1, g1, b1});
    end
    cyc(1'b0, 100, 100, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0} !== 24'h0000FF || {r1, g1, b1} !== 24'h0000FF) begin
      miscompares++; $display("FAIL text_mask_off got %h/%h exp 0000ff", {r0, g0, b0}, {r1, g1, b1});
    end
  endtask

  task automatic test_level_latch();
    cyc(1'b0, 0, 0, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 5, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 3, 200, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0} !== 24'hFFFFFF) begin
      miscompares++; $display("FAIL level_midframe got %h exp ffffff", {r0, g0, b0});
    end
    cyc(1'b0, 0, 0, 1'b1, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0} !== 24'hFFFFFF) begin
      miscompares++; $display("FAIL level_hold got %h exp ffffff", {r0, g0, b0});
    end
    cyc(1'b0, 639, 479, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0} !== 24'h00FFFF) begin
      miscompares++; $display("FAIL level_new got %h exp 00ffff", {r0, g0, b0});
    end
    cyc(1'b0, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({r0, g0, b0} !== 24'h0 || pvo0 !== 1'b0) begin
      miscompares++; $display("FAIL invalid_black got %h pvo %b exp 0", {r0, g0, b0}, pvo0);
    end
  endtask

  task automatic test_border_edges();
    int xs[7] = '{14, 15, 625, 100, 640, 624, 100};
    int ys[7] = '{100, 100, 100, 465, 100, 100, 480};
    bit eb[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, xs[i], ys[i], 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bh0 !== eb[i] || bh1 !== eb[i]) begin
        miscompares++; $display("FAIL border_edge x=%0d y=%0d got %b exp %b", xs[i], ys[i], bh0, eb[i]);
      end
    end
  endtask

  task automatic test_random_play();
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0, NL'($urandom & $urandom), $urandom_range(0, 1),
          $urandom_range(0, 1), 1'b0, 1'b0);
      vectors++;
      if ({r0, g0, b0} !== exp0 || {r1, g1, b1} !== exp1) begin
        miscompares++; $display("FAIL play_rgb got %h/%h exp %h/%h", {r0, g0, b0}, {r1, g1, b1}, exp0, exp1);
      end
      vectors++;
      if (pvo0 !== exp_pv || bh0 !== exp_bh || bh1 !== exp_bh || md0 !== 2'(m_mode)) begin
        miscompares++; $display("FAIL play_ctl pvo %b bh %b mode %0d exp %b %b %0d", pvo0, bh0, md0, exp_pv, exp_bh, m_mode);
      end
    end
  endtask

  task automatic test_lose_flash();
    int prev_f = -1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 200, 200, 1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (md0 !== 2'd0) begin
        miscompares++; $display("FAIL lose_midframe mode got %0d exp 0", md0);
      end
    end
    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 4; p++) begin
        cyc(1'b0, $urandom_range(0, 639), $urandom_range(0, 479), 1'b1, p == 0,
            NL'($urandom), 1'b1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        vectors++;
        if (md0 !== 2'd2 || md1 !== 2'd2) begin
          miscompares++; $display("FAIL lose_mode got %0d exp 2", md0);
        end
        if (prev_f >= 0) begin
          vectors++;
          if ({r0, g0, b0} !== ((prev_f / 2) % 2 == 0 ? 24'hFF0000 : 24'h0) || {r1, g1, b1} !== exp1) begin
            miscompares++; $display("FAIL lose_flash frame %0d got %h/%h", prev_f, {r0, g0, b0}, {r1, g1, b1});
          end
        end
        prev_f = f;
      end
    end
  endtask

  task automatic test_win_random();
    for (int i = 0; i < 3; i++) cyc(1'b1, 0, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 50, 50, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (md0 !== 2'd1) begin
      miscompares++; $display("FAIL win_enter mode got %0d exp 1", md0);
    end
    for (int i = 0; i < 150; i++) begin
      cyc(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) == 0, NL'($urandom), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      vectors++;
      if ({r0, g0, b0} !== exp0 || {r1, g1, b1} !== exp1 || md0 !== 2'd1) begin
        miscompares++; $display("FAIL win_rgb got %h/%h mode %0d exp %h/%h 1", {r0, g0, b0}, {r1, g1, b1}, md0, exp0, exp1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority_blend();
    test_text_mask();
    test_level_latch();
    test_border_edges();
    test_random_play();
    test_lose_flash();
    test_win_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
